instr_decoder_ws: RTL and testbench

- Next-generation NLP-16AF instruction decoder/sequencer.
- Same multi-cycle fetch/decode/execute FSM and datapath control outputs as the current decoder.
- Adds a memory ready handshake with wait states, a parametrised wait timeout that enters a sticky error state, a HALT instruction with a resume input, and a unified extension-word fetch.
- Sits between the IR1/IR2 registers and the register file / ALU / memory bus controls.

---
 rtl/instr_decoder_ws.sv | 223 ++++++++++++++++++++++
 tb/tb_instr_decoder_ws.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_decoder_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_decoder_ws                                                |
// | Brief    : NLP-16AF fetch/decode/execute sequencer with memory wait states,|
// |            wait timeout to a sticky error state, HALT/resume and ext word. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module instr_decoder_ws #(
  parameter bit         WAIT_EN = 1'b1,
  parameter int         TO_W    = 8,
  parameter int         TIMEOUT = 255,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_ir1,
  input  logic [15:0] i_ir2,
  input  logic        i_mem_ack,
  input  logic        i_resume,
  input  logic [3:0]  i_flag_cond,
  output logic [3:0]  o_state,
  output logic        o_err,
  output logic        o_halted,
  output logic [5:0]  o_alu_op,
  output logic [3:0]  o_s1_addr,
  output logic [3:0]  o_s2_addr,
  output logic [3:0]  o_dest_addr,
  output logic [3:0]  o_addr_reg,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic        o_reg_w_en,
  output logic        o_flag_w_en
);

  typedef enum logic [3:0] {
    S_IF1   = 4'd0,  S_D1    = 4'd1,  S_IF2   = 4'd2,  S_D2    = 4'd3,
    S_IFX   = 4'd4,  S_DX    = 4'd5,  S_PUSH1 = 4'd6,  S_PUSH2 = 4'd7,
    S_POP1  = 4'd8,  S_POP2  = 4'd9,  S_EXE   = 4'd10, S_EXEA  = 4'd11,
    S_RD    = 4'd12, S_WR    = 4'd13, S_HALT  = 4'd14, S_ERR   = 4'd15
  } state_t;

  // Special register ids on the register-file address buses
  localparam logic [3:0] c_reg_zr   = 4'h0;
  localparam logic [3:0] c_reg_ir1  = 4'h9;
  localparam logic [3:0] c_reg_ir2  = 4'hA;
  localparam logic [3:0] c_reg_ir3  = 4'hB;
  localparam logic [3:0] c_reg_addr = 4'hC;
  localparam logic [3:0] c_reg_mem  = 4'hD;
  localparam logic [3:0] c_reg_sp   = 4'hE;
  localparam logic [3:0] c_reg_ip   = 4'hF;

  localparam logic [5:0] c_alu_mov = 6'h3C;
  localparam logic [5:0] c_alu_inc = 6'h3D;
  localparam logic [5:0] c_alu_dec = 6'h3E;

  localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT);

  state_t          state_q, state_d, w_nxt;
  logic [TO_W-1:0] wait_q, wait_d;

  logic [3:0] w_op, w_ra1, w_ra2, w_ra3;
  logic [2:0] w_ftype;
  logic       w_finv, w_cond, w_ext;
  logic       w_is_alu, w_is_load, w_is_store, w_is_call, w_is_pop, w_is_push, w_is_halt;
  logic [5:0] w_alu_op;
  logic       w_mem_state, w_wb_state, w_held, w_wb, w_dir_wr;

  assign w_op       = i_ir1[15:12];
  assign w_ra1      = i_ir1[3:0];
  assign w_ra2      = i_ir2[15:12];
  assign w_ra3      = i_ir2[11:8];
  assign w_ftype    = i_ir1[7:5];
  assign w_finv     = i_ir1[4];
  assign w_is_alu   = (w_op[3:2] == 2'b00);
  assign w_is_load  = (w_op == 4'b1000);
  assign w_is_store = (w_op == 4'b1001);
  assign w_is_call  = (w_op == 4'b1011);
  assign w_is_pop   = (w_op == 4'b1100);
  assign w_is_push  = (w_op == 4'b1101);
  assign w_is_halt  = (w_op == HALT_OP);
  assign w_alu_op   = w_is_alu ? i_ir1[13:8] : {2'b00, i_ir1[11:8]};
  assign w_ext      = (w_ra2 == c_reg_ir3) | (w_ra3 == c_reg_ir3);

  // Flag select: 000 NOP, 001 C, 010 S, 011 Z, 100 V; i_flag_cond = {C,S,V,Z}
  always_comb begin
    w_cond = 1'b0;
    case (w_ftype)
      3'b000:  w_cond = w_finv;
      3'b001:  w_cond = i_flag_cond[3] ^ w_finv;
      3'b010:  w_cond = i_flag_cond[2] ^ w_finv;
      3'b011:  w_cond = i_flag_cond[0] ^ w_finv;
      3'b100:  w_cond = i_flag_cond[1] ^ w_finv;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_mem_state = (state_q == S_IF1)   || (state_q == S_IF2)  || (state_q == S_IFX) ||
                       (state_q == S_PUSH2) || (state_q == S_POP1) || (state_q == S_RD)  ||
                       (state_q == S_WR);
  assign w_wb_state  = (state_q == S_EXE)   || (state_q == S_EXEA) || (state_q == S_RD)  ||
                       (state_q == S_WR)    || (state_q == S_PUSH1)|| (state_q == S_PUSH2) ||
                       (state_q == S_POP1)  || (state_q == S_POP2);
  assign w_held      = WAIT_EN && w_mem_state && !i_mem_ack;
  assign w_wb        = w_wb_state ? w_cond : 1'b1;

  always_comb begin
    w_nxt = S_ERR;
    case (state_q)
      S_IF1:   w_nxt = S_D1;
      S_D1:    w_nxt = w_is_halt ? S_HALT : w_is_push ? S_PUSH1 : w_is_pop ? S_POP1 : S_IF2;
      S_IF2:   w_nxt = S_D2;
      S_D2:    w_nxt = w_ext ? S_IFX : w_is_call ? S_PUSH1 :
                       (w_is_load || w_is_store) ? S_EXEA : S_EXE;
      S_IFX:   w_nxt = S_DX;
      S_DX:    w_nxt = w_is_call ? S_PUSH1 : (w_is_load || w_is_store) ? S_EXEA : S_EXE;
      S_PUSH1: w_nxt = S_PUSH2;
      S_PUSH2: w_nxt = w_is_call ? S_EXE : S_IF1;
      S_POP1:  w_nxt = S_POP2;
      S_POP2:  w_nxt = S_IF1;
      S_EXE:   w_nxt = S_IF1;
      S_EXEA:  w_nxt = w_is_load ? S_RD : S_WR;
      S_RD:    w_nxt = S_IF1;
      S_WR:    w_nxt = S_IF1;
      S_HALT:  w_nxt = i_resume ? S_IF1 : S_HALT;
      S_ERR:   w_nxt = S_ERR;
      default: w_nxt = S_ERR;
    endcase
  end

  // A held cycle counts toward the timeout; the count that would reach TIMEOUT diverts to ERR
  always_comb begin
    wait_d  = '0;
    state_d = w_nxt;
    if (w_held) begin
      wait_d  = wait_q + TO_W'(1);
      state_d = state_q;
      if ((TIMEOUT != 0) && (wait_d == c_timeout)) begin
        state_d = S_ERR;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IF1;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    o_alu_op    = c_alu_mov;
    o_dest_addr = c_reg_zr;
    o_s1_addr   = c_reg_zr;
    o_s2_addr   = c_reg_zr;
    o_addr_reg  = c_reg_zr;
    case (state_q)
      S_IF1, S_IF2, S_IFX: begin
        o_dest_addr = (state_q == S_IF1) ? c_reg_ir1 : (state_q == S_IF2) ? c_reg_ir2 : c_reg_ir3;
        o_s1_addr   = c_reg_mem;
        o_addr_reg  = c_reg_ip;
      end
      S_D1, S_D2, S_DX: begin
        o_alu_op    = c_alu_inc;
        o_dest_addr = c_reg_ip;
        o_s1_addr   = c_reg_ip;
        o_addr_reg  = c_reg_ip;
      end
      S_PUSH1: begin
        o_alu_op    = c_alu_dec;
        o_dest_addr = c_reg_sp;
        o_s1_addr   = c_reg_sp;
        o_addr_reg  = c_reg_sp;
      end
      S_PUSH2: begin
        o_dest_addr = c_reg_mem;
        o_s1_addr   = w_ra1;
        o_addr_reg  = c_reg_sp;
      end
      S_POP1: begin
        o_dest_addr = w_ra1;
        o_s1_addr   = c_reg_mem;
        o_addr_reg  = c_reg_sp;
      end
      S_POP2: begin
        o_alu_op    = c_alu_inc;
        o_dest_addr = c_reg_sp;
        o_s1_addr   = c_reg_sp;
        o_addr_reg  = c_reg_sp;
      end
      S_EXE, S_EXEA: begin
        o_alu_op    = w_alu_op;
        o_dest_addr = (state_q == S_EXE) ? w_ra1 : c_reg_addr;
        o_s1_addr   = w_ra2;
        o_s2_addr   = w_ra3;
      end
      S_RD: begin
        o_dest_addr = w_ra1;
        o_s1_addr   = c_reg_mem;
        o_addr_reg  = c_reg_addr;
      end
      S_WR: begin
        o_dest_addr = c_reg_mem;
        o_s1_addr   = w_ra1;
        o_addr_reg  = c_reg_addr;
      end
      default: ;
    endcase
  end

  assign w_dir_wr    = (o_dest_addr == c_reg_mem);
  assign o_mem_rd    = !w_dir_wr && ((o_s1_addr == c_reg_mem) || (o_s2_addr == c_reg_mem));
  assign o_reg_w_en  = w_wb && !w_held && (state_q != S_HALT) && (state_q != S_ERR);
  assign o_mem_wr    = o_reg_w_en && w_dir_wr;
  assign o_flag_w_en = w_wb && (state_q == S_EXE);
  assign o_state     = state_q;
  assign o_err       = (state_q == S_ERR);
  assign o_halted    = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_decoder_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instr_decoder_ws                                             |
// | Brief    : Directed self-checking bench for instr_decoder_ws (TIMEOUT=4).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_instr_decoder_ws;

  localparam logic [3:0] c_reg_ir1  = 4'h9;
  localparam logic [3:0] c_reg_ir3  = 4'hB;
  localparam logic [3:0] c_reg_addr = 4'hC;
  localparam logic [3:0] c_reg_mem  = 4'hD;
  localparam logic [3:0] c_reg_sp   = 4'hE;
  localparam logic [3:0] c_reg_ip   = 4'hF;
  localparam logic [5:0] c_alu_dec  = 6'h3E;

  logic        i_clk, i_rst_n, i_mem_ack, i_resume;
  logic [15:0] i_ir1, i_ir2;
  logic [3:0]  i_flag_cond;
  logic [3:0]  o_state, o_s1_addr, o_s2_addr, o_dest_addr, o_addr_reg;
  logic [5:0]  o_alu_op;
  logic        o_err, o_halted, o_mem_rd, o_mem_wr, o_reg_w_en, o_flag_w_en;

  int n_checks = 0;
  int n_errors = 0;

  instr_decoder_ws #(
    .WAIT_EN (1'b1),
    .TO_W    (8),
    .TIMEOUT (4),
    .HALT_OP (4'b1111)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ir1       (i_ir1),
    .i_ir2       (i_ir2),
    .i_mem_ack   (i_mem_ack),
    .i_resume    (i_resume),
    .i_flag_cond (i_flag_cond),
    .o_state     (o_state),
    .o_err       (o_err),
    .o_halted    (o_halted),
    .o_alu_op    (o_alu_op),
    .o_s1_addr   (o_s1_addr),
    .o_s2_addr   (o_s2_addr),
    .o_dest_addr (o_dest_addr),
    .o_addr_reg  (o_addr_reg),
    .o_mem_rd    (o_mem_rd),
    .o_mem_wr    (o_mem_wr),
    .o_reg_w_en  (o_reg_w_en),
    .o_flag_w_en (o_flag_w_en)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic step_state(input string tag, input logic [3:0] exp_state);
    tick();
    chk(tag, 16'(o_state), 16'(exp_state));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_mem_ack = 1'b1; i_resume = 1'b0; i_flag_cond = 4'b0000;
    i_ir1 = 16'h0013; i_ir2 = 16'h2300;
    #12 i_rst_n = 1'b1;
    #1;
    chk("rst_state",  16'(o_state), 16'd0);
    chk("rst_err",    16'(o_err), 16'd0);
    chk("rst_halted", 16'(o_halted), 16'd0);
    chk("rst_dest",   16'(o_dest_addr), 16'(c_reg_ir1));
    chk("rst_s1",     16'(o_s1_addr), 16'(c_reg_mem));
    chk("rst_addr",   16'(o_addr_reg), 16'(c_reg_ip));
    chk("rst_mem_rd", 16'(o_mem_rd), 16'd1);
    chk("rst_wen",    16'(o_reg_w_en), 16'd1);

    // ADD, no extension word
    step_state("add_d1", 4'd1);
    step_state("add_if2", 4'd2);
    step_state("add_d2", 4'd3);
    step_state("add_exe", 4'd10);
    chk("add_dest", 16'(o_dest_addr), 16'd3);
    chk("add_s1",   16'(o_s1_addr), 16'd2);
    chk("add_s2",   16'(o_s2_addr), 16'd3);
    chk("add_alu",  16'(o_alu_op), 16'h00);
    chk("add_wen",  16'(o_reg_w_en), 16'd1);
    chk("add_fwen", 16'(o_flag_w_en), 16'd1);
    step_state("add_if1", 4'd0);

    // Load with extension word and three wait states in RD
    i_ir1 = 16'h8015; i_ir2 = 16'hB200;
    step_state("ld_d1", 4'd1);
    step_state("ld_if2", 4'd2);
    step_state("ld_d2", 4'd3);
    step_state("ld_ifx", 4'd4);
    chk("ld_ifx_dest", 16'(o_dest_addr), 16'(c_reg_ir3));
    step_state("ld_dx", 4'd5);
    step_state("ld_exea", 4'd11);
    chk("ld_exea_dest", 16'(o_dest_addr), 16'(c_reg_addr));
    i_mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_state("ld_rd_hold", 4'd12);
      chk("ld_hold_wen", 16'(o_reg_w_en), 16'd0);
      chk("ld_hold_rd",  16'(o_mem_rd), 16'd1);
      chk("ld_hold_adr", 16'(o_addr_reg), 16'(c_reg_addr));
    end
    i_mem_ack = 1'b1;
    #1;
    chk("ld_ack_wen",  16'(o_reg_w_en), 16'd1);
    chk("ld_ack_dest", 16'(o_dest_addr), 16'd5);
    chk("ld_ack_rd",   16'(o_mem_rd), 16'd1);
    step_state("ld_if1", 4'd0);

    // Conditional ALU op on Z, false then true
    i_ir1 = 16'h0163; i_ir2 = 16'h2300; i_flag_cond = 4'b0000;
    step_state("cz0_d1", 4'd1);
    step_state("cz0_if2", 4'd2);
    step_state("cz0_d2", 4'd3);
    chk("cz0_d2_wen", 16'(o_reg_w_en), 16'd1);
    step_state("cz0_exe", 4'd10);
    chk("cz0_alu",  16'(o_alu_op), 16'h01);
    chk("cz0_wen",  16'(o_reg_w_en), 16'd0);
    chk("cz0_fwen", 16'(o_flag_w_en), 16'd0);
    step_state("cz0_if1", 4'd0);
    i_flag_cond = 4'b0001;
    tick(); tick(); tick();
    step_state("cz1_exe", 4'd10);
    chk("cz1_wen",  16'(o_reg_w_en), 16'd1);
    chk("cz1_fwen", 16'(o_flag_w_en), 16'd1);
    step_state("cz1_if1", 4'd0);

    // Store conditional on C (true)
    i_ir1 = 16'h9024; i_ir2 = 16'h1200; i_flag_cond = 4'b1000;
    tick(); tick(); tick();
    step_state("st_exea", 4'd11);
    step_state("st_wr", 4'd13);
    chk("st_mem_wr", 16'(o_mem_wr), 16'd1);
    chk("st_mem_rd", 16'(o_mem_rd), 16'd0);
    chk("st_s1",     16'(o_s1_addr), 16'd4);
    chk("st_addr",   16'(o_addr_reg), 16'(c_reg_addr));
    step_state("st_if1", 4'd0);

    // Push
    i_ir1 = 16'hD017; i_flag_cond = 4'b0000;
    step_state("push_d1", 4'd1);
    step_state("push_p1", 4'd6);
    chk("push1_alu",  16'(o_alu_op), 16'(c_alu_dec));
    chk("push1_dest", 16'(o_dest_addr), 16'(c_reg_sp));
    step_state("push_p2", 4'd7);
    chk("push2_mem_wr", 16'(o_mem_wr), 16'd1);
    chk("push2_addr",   16'(o_addr_reg), 16'(c_reg_sp));
    chk("push2_s1",     16'(o_s1_addr), 16'd7);
    step_state("push_if1", 4'd0);

    // HALT and resume
    i_ir1 = 16'hF000;
    step_state("halt_d1", 4'd1);
    for (int k = 0; k < 5; k++) begin
      step_state("halt_state", 4'd14);
      chk("halt_flag", 16'(o_halted), 16'd1);
      chk("halt_wen",  16'(o_reg_w_en), 16'd0);
    end
    i_resume = 1'b1;
    step_state("resume_if1", 4'd0);
    chk("resume_halted", 16'(o_halted), 16'd0);

    // Wait timeout in IF1, then asynchronous reset out of ERR
    i_resume = 1'b0; i_mem_ack = 1'b0;
    #1;
    chk("to_hold1", 16'(o_state), 16'd0);
    chk("to_wen",   16'(o_reg_w_en), 16'd0);
    for (int k = 0; k < 3; k++) step_state("to_hold", 4'd0);
    step_state("to_err", 4'd15);
    chk("to_err_flag", 16'(o_err), 16'd1);
    i_mem_ack = 1'b1;
    step_state("err_sticky", 4'd15);
    step_state("err_sticky2", 4'd15);
    chk("err_wen", 16'(o_reg_w_en), 16'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_state", 16'(o_state), 16'd0);
    chk("arst_err",   16'(o_err), 16'd0);
    #3 i_rst_n = 1'b1;
    step_state("post_rst_d1", 4'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
